// File: rtl/crossbar_islip_sched.sv
// Single-iteration iSLIP scheduler for a 4x4 crossbar.
// One grant/accept round is computed per enabled cycle, and every output is registered.
module crossbar_islip_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_en,
  input  logic [3:0]       req0,
  input  logic [3:0]       req1,
  input  logic [3:0]       req2,
  input  logic [3:0]       req3,
  output logic [3:0]       out_vld,
  output logic [1:0]       out_sel0,
  output logic [1:0]       out_sel1,
  output logic [1:0]       out_sel2,
  output logic [1:0]       out_sel3,
  output logic [3:0]       in_vld,
  output logic [1:0]       in_dst0,
  output logic [1:0]       in_dst1,
  output logic [1:0]       in_dst2,
  output logic [1:0]       in_dst3,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned N     = 4;
  localparam int unsigned SUM_W = CNT_W + 3;

  logic [N-1:0]     req_m [N];
  logic [1:0]       gp [N];
  logic [1:0]       ap [N];
  logic [1:0]       sel_q [N];
  logic [1:0]       dst_q [N];

  logic [N-1:0]     gnt_vld_c;
  logic [1:0]       gnt_idx_c [N];
  logic [N-1:0]     acc_vld_c;
  logic [1:0]       acc_idx_c [N];
  logic [N-1:0]     out_m_c;
  logic [2:0]       pop_c;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  assign req_m[0] = req0;
  assign req_m[1] = req1;
  assign req_m[2] = req2;
  assign req_m[3] = req3;

  assign out_sel0 = sel_q[0];
  assign out_sel1 = sel_q[1];
  assign out_sel2 = sel_q[2];
  assign out_sel3 = sel_q[3];
  assign in_dst0  = dst_q[0];
  assign in_dst1  = dst_q[1];
  assign in_dst2  = dst_q[2];
  assign in_dst3  = dst_q[3];

  // Grant: each output picks the first requesting input at or after its pointer.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      gnt_vld_c[j] = 1'b0;
      gnt_idx_c[j] = 2'd0;
      for (int k = 0; k < N; k++) begin
        if (!gnt_vld_c[j] && req_m[2'(gp[j] + 2'(k))][j]) begin
          gnt_vld_c[j] = 1'b1;
          gnt_idx_c[j] = 2'(gp[j] + 2'(k));
        end
      end
    end
  end

  // Accept: each input picks the first granting output at or after its pointer.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_vld_c[i] = 1'b0;
      acc_idx_c[i] = 2'd0;
      for (int k = 0; k < N; k++) begin
        if (!acc_vld_c[i] && gnt_vld_c[2'(ap[i] + 2'(k))] &&
            gnt_idx_c[2'(ap[i] + 2'(k))] == 2'(i)) begin
          acc_vld_c[i] = 1'b1;
          acc_idx_c[i] = 2'(ap[i] + 2'(k));
        end
      end
    end
  end

  // Output-side view of the accepted pairs, plus the saturating counter update.
  always_comb begin
    out_m_c = '0;
    pop_c   = 3'd0;
    for (int j = 0; j < N; j++) begin
      out_m_c[j] = gnt_vld_c[j] && acc_vld_c[gnt_idx_c[j]] &&
                   (acc_idx_c[gnt_idx_c[j]] == 2'(j));
    end
    for (int i = 0; i < N; i++) begin
      pop_c = pop_c + 3'(acc_vld_c[i]);
    end
    sum_c     = SUM_W'(match_cnt) + SUM_W'(pop_c);
    cnt_nxt_c = (sum_c > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sum_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= '0;
      in_vld    <= '0;
      match_cnt <= '0;
      for (int n = 0; n < N; n++) begin
        gp[n]    <= 2'd0;
        ap[n]    <= 2'd0;
        sel_q[n] <= 2'd0;
        dst_q[n] <= 2'd0;
      end
    end else if (sched_en) begin
      out_vld   <= out_m_c;
      in_vld    <= acc_vld_c;
      match_cnt <= cnt_nxt_c;
      for (int j = 0; j < N; j++) begin
        sel_q[j] <= out_m_c[j] ? gnt_idx_c[j] : 2'd0;
        if (out_m_c[j]) gp[j] <= 2'(gnt_idx_c[j] + 2'd1);
      end
      for (int i = 0; i < N; i++) begin
        dst_q[i] <= acc_vld_c[i] ? acc_idx_c[i] : 2'd0;
        if (acc_vld_c[i]) ap[i] <= 2'(acc_idx_c[i] + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_crossbar_islip_sched.sv
// Bench for crossbar_islip_sched: random traffic against a cycle-level iSLIP model, plus
// literal expectations for the known start-up sequence.
module tb_crossbar_islip_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sched_en;
  logic [3:0] req0, req1, req2, req3;

  logic [3:0]  out_vld, in_vld;
  logic [1:0]  out_sel0, out_sel1, out_sel2, out_sel3;
  logic [1:0]  in_dst0, in_dst1, in_dst2, in_dst3;
  logic [15:0] match_cnt;

  logic [3:0]  s_out_vld, s_in_vld;
  logic [1:0]  s_out_sel0, s_out_sel1, s_out_sel2, s_out_sel3;
  logic [1:0]  s_in_dst0, s_in_dst1, s_in_dst2, s_in_dst3;
  logic [2:0]  s_match_cnt;

  crossbar_islip_sched dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .out_vld(out_vld),
    .out_sel0(out_sel0), .out_sel1(out_sel1), .out_sel2(out_sel2), .out_sel3(out_sel3),
    .in_vld(in_vld),
    .in_dst0(in_dst0), .in_dst1(in_dst1), .in_dst2(in_dst2), .in_dst3(in_dst3),
    .match_cnt(match_cnt)
  );

  crossbar_islip_sched #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .out_vld(s_out_vld),
    .out_sel0(s_out_sel0), .out_sel1(s_out_sel1), .out_sel2(s_out_sel2), .out_sel3(s_out_sel3),
    .in_vld(s_in_vld),
    .in_dst0(s_in_dst0), .in_dst1(s_in_dst1), .in_dst2(s_in_dst2), .in_dst3(s_in_dst3),
    .match_cnt(s_match_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: plain integer pointers and the expected output image.
  int m_gp [4];
  int m_ap [4];
  int m_osel [4];
  int m_idst [4];
  logic [3:0] m_ovld, m_ivld;
  int m_cnt, m_cnt3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] col(input int j);
    logic [3:0] c;
    c = {req3[j], req2[j], req1[j], req0[j]};
    return c;
  endfunction

  // One iSLIP round computed from the rules, applied to the reference state.
  task automatic model_edge();
    int g [4];
    int a [4];
    int n;
    logic [3:0] c;
    if (rst) begin
      for (int x = 0; x < 4; x++) begin
        m_gp[x] = 0; m_ap[x] = 0; m_osel[x] = 0; m_idst[x] = 0;
      end
      m_ovld = 4'b0; m_ivld = 4'b0; m_cnt = 0; m_cnt3 = 0;
    end else if (sched_en) begin
      for (int j = 0; j < 4; j++) begin
        g[j] = -1;
        c = col(j);
        for (int k = 0; k < 4; k++)
          if (g[j] < 0 && c[(m_gp[j] + k) % 4]) g[j] = (m_gp[j] + k) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        a[i] = -1;
        for (int k = 0; k < 4; k++)
          if (a[i] < 0 && g[(m_ap[i] + k) % 4] == i) a[i] = (m_ap[i] + k) % 4;
      end
      m_ovld = 4'b0; m_ivld = 4'b0; n = 0;
      for (int x = 0; x < 4; x++) begin m_osel[x] = 0; m_idst[x] = 0; end
      for (int i = 0; i < 4; i++) begin
        if (a[i] >= 0) begin
          m_ivld[i] = 1'b1;       m_idst[i] = a[i];
          m_ovld[a[i]] = 1'b1;    m_osel[a[i]] = i;
          m_gp[a[i]] = (i + 1) % 4;
          m_ap[i] = (a[i] + 1) % 4;
          n++;
        end
      end
      m_cnt  = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
      m_cnt3 = (m_cnt3 + n > 7) ? 7 : m_cnt3 + n;
    end
  endtask

  task automatic compare_all();
    logic [1:0] sel [4];
    logic [1:0] dst [4];
    int po, pi;
    sel = '{out_sel0, out_sel1, out_sel2, out_sel3};
    dst = '{in_dst0, in_dst1, in_dst2, in_dst3};
    chk("out_vld", 32'(out_vld), 32'(m_ovld));
    chk("in_vld", 32'(in_vld), 32'(m_ivld));
    for (int x = 0; x < 4; x++) begin
      chk($sformatf("out_sel%0d", x), 32'(sel[x]), 32'(m_osel[x]));
      chk($sformatf("in_dst%0d", x), 32'(dst[x]), 32'(m_idst[x]));
    end
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("match_cnt_w3", 32'(s_match_cnt), 32'(m_cnt3));
    chk("w3_out_vld", 32'(s_out_vld), 32'(m_ovld));
    // Model-independent pairing consistency between the two output views.
    po = 0; pi = 0;
    for (int j = 0; j < 4; j++) if (out_vld[j]) begin
      po++;
      chk("consist_out", 32'({in_vld[sel[j]], dst[sel[j]]}), 32'({1'b1, 2'(j)}));
    end
    for (int i = 0; i < 4; i++) if (in_vld[i]) begin
      pi++;
      chk("consist_in", 32'({out_vld[dst[i]], sel[dst[i]]}), 32'({1'b1, 2'(i)}));
    end
    chk("pair_count", 32'(po), 32'(pi));
  endtask

  task automatic step(input logic r, input logic en,
                      input logic [3:0] r0, input logic [3:0] r1,
                      input logic [3:0] r2, input logic [3:0] r3);
    @(negedge clk);
    rst = r; sched_en = en; req0 = r0; req1 = r1; req2 = r2; req3 = r3;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic r, en;
    logic [3:0] q [4];
    rst = 1'b1; sched_en = 1'b0; req0 = '0; req1 = '0; req2 = '0; req3 = '0;
    for (int x = 0; x < 4; x++) begin m_gp[x] = 0; m_ap[x] = 0; end

    // Reset state, with a request pattern present to show reset priority.
    step(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset_out_vld", 32'(out_vld), 32'h0);
    chk("reset_cnt", 32'(match_cnt), 32'h0);

    // Full-load start-up sequence.
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("d1_out_vld", 32'(out_vld), 32'h1);
    chk("d1_cnt", 32'(match_cnt), 32'd1);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("d2_out_vld", 32'(out_vld), 32'h3);
    chk("d2_sel", 32'({out_sel1, out_sel0}), 32'({2'd0, 2'd1}));
    chk("d2_cnt", 32'(match_cnt), 32'd3);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("d3_out_vld", 32'(out_vld), 32'h7);
    chk("d3_dst", 32'({in_dst2, in_dst1, in_dst0}), 32'({2'd0, 2'd1, 2'd2}));
    chk("d3_cnt", 32'(match_cnt), 32'd6);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("d4_out_vld", 32'(out_vld), 32'hF);
    chk("d4_cnt", 32'(match_cnt), 32'd10);
    chk("d4_sat_cnt", 32'(s_match_cnt), 32'd7);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("desync_out_vld", 32'(out_vld), 32'hF);
    chk("desync_cnt", 32'(match_cnt), 32'd34);
    chk("sat_hold", 32'(s_match_cnt), 32'd7);

    // Reset during full load, then the first decision repeats.
    step(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("midrst_out_vld", 32'(out_vld), 32'h0);
    chk("midrst_cnt", 32'(match_cnt), 32'h0);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("postrst_out_vld", 32'(out_vld), 32'h1);
    chk("postrst_cnt", 32'(match_cnt), 32'd1);

    // Single request in2 -> out3 after a fresh reset.
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 4'h0, 4'h0, 4'h8, 4'h0);
    chk("single_out_vld", 32'(out_vld), 32'h8);
    chk("single_sel3", 32'(out_sel3), 32'd2);
    chk("single_in_vld", 32'(in_vld), 32'h4);
    chk("single_dst2", 32'(in_dst2), 32'd3);
    // gp3 is now 3, so output 3 prefers input 3 over input 0.
    step(1'b0, 1'b1, 4'h8, 4'h0, 4'h0, 4'h8);
    chk("gp3_sel3", 32'(out_sel3), 32'd3);

    // Frozen cycles with changing requests.
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    chk("frozen_sel3", 32'(out_sel3), 32'd3);
    chk("frozen_cnt", 32'(match_cnt), 32'd2);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);

    // All-zero request matrix.
    step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("zero_out_vld", 32'(out_vld), 32'h0);
    chk("zero_in_vld", 32'(in_vld), 32'h0);

    // Random traffic with mixed density, stalls and rare resets.
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 4) != 0);
      for (int x = 0; x < 4; x++)
        q[x] = (c % 3 == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom) | 4'($urandom);
      step(r, en, q[0], q[1], q[2], q[3]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_islip_sched.md
CROSSBAR_ISLIP_SCHED -- requirements
Module: crossbar_islip_sched

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating match-statistics counter.
REQ-002 Port: clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sched_en  input  1  high = run one scheduling decision this cycle; low = hold all state and outputs.
REQ-005 Port: req0..req3  input  4 each  VOQ occupancy of input i; bit j set = input i holds a cell for output j.
REQ-006 Port: out_vld  output  4  bit j set = output j matched this decision.
REQ-007 Port: out_sel0..out_sel3  output  2 each  input index driving output j; valid only when out_vld[j]=1, else 0.
REQ-008 Port: in_vld  output  4  bit i set = input i matched; the input dequeues its head cell for in_dst_i.
REQ-009 Port: in_dst0..in_dst3  output  2 each  output index granted to input i; valid only when in_vld[i]=1, else 0.
REQ-010 Port: match_cnt  output  CNT_W  running total of matched pairs, saturating at all-ones.

Function
REQ-011 State: grant pointer gp_j (2 bit) per output; accept pointer ap_i (2 bit) per input.
REQ-012 Grant: for each output j, the chosen input is the first i with req_i[j]=1, searching cyclically from gp_j (gp_j, gp_j+1, ... mod 4); no requester = no grant.
REQ-013 Accept: for each input i, the chosen output is the first j granting i, searching cyclically from ap_i; no grant = no accept.
REQ-014 Match: pairs (i,j) with output j granting i and input i accepting j; at most one pair per input and per output.
REQ-015 Pointer update: only for accepted pairs, gp_j <= (i+1) mod 4 and ap_i <= (j+1) mod 4. Unaccepted grants leave gp_j unchanged. Unmatched inputs keep ap_i.
REQ-016 Single iteration per decision; unmatched ports are not re-arbitrated in the same cycle.
REQ-017 Latency: req sampled at edge k with sched_en=1; out_*/in_* reflect that decision after edge k and hold until the next decision edge.
REQ-018 sched_en=0 at an edge: pointers, out_*, in_*, match_cnt unchanged.
REQ-019 Consistency: out_vld[j]=1 with out_sel_j=i iff in_vld[i]=1 with in_dst_i=j.
REQ-020 match_cnt += popcount(accepted pairs) per decision; result clamps to 2^CNT_W-1 and never wraps.
REQ-021 All outputs are registered; there is no combinational path from req to any output.
REQ-022 An all-zero request matrix with sched_en=1 produces out_vld=0, in_vld=0, all selects 0, and no pointer change.

Reset
REQ-023 rst=1 at an edge sets all gp_j=0, all ap_i=0, out_vld=0, in_vld=0, all out_sel/in_dst=0 and match_cnt=0.
REQ-024 rst takes priority over sched_en; asserting it mid-operation discards the in-flight decision and clears state in the same edge.
REQ-025 The first decision after rst deasserts uses the reset pointer values.

Verification
REQ-026 Reset, then req0..3=4'b1111 with sched_en=1 -> decision 1: only in0->out0, out_vld=4'b0001, match_cnt=1. Decision 2: in0->out1 and in1->out0, out_vld=4'b0011, match_cnt=3.
REQ-027 Continuing REQ-026 -> decision 3: in0->out2, in1->out1, in2->out0, out_vld=4'b0111, match_cnt=6. Full load thereafter reaches 4 matches per decision (desynchronisation).
REQ-028 Only req2=4'b1000 -> out_vld=4'b1000, out_sel3=2, in_vld=4'b0100, in_dst2=3. Then gp3=3, ap2=0.
REQ-029 sched_en=0 for 3 cycles with changing req -> outputs and match_cnt stay frozen. The next enabled decision uses the unchanged pointers.
REQ-030 rst asserted during full-load traffic -> all outputs 0 at the next edge. The following decision repeats the REQ-026 decision-1 result.
REQ-031 CNT_W=3 under full load -> match_cnt saturates at 7 and holds. Random-traffic checker enforces REQ-014 and REQ-019 every decision.
